// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
//
// Hardwired control unit for the single-bus datapath. Steps the
// fetch/execute T-states and drives the bus-out, register-in, ALU CONTROL
// and memory-strobe signals. Covers register-register ALU ops, unary
// neg/not, nop and halt.
//
// Every output is a pure decode of the state register (plus the IR fields
// in T3..T5 and Mem_Ready in T1). IR is loaded on the edge that ends T2,
// so the IR-dependent strobes cannot be precomputed into flops on the edge
// that enters T3. Because they hang directly off the state register, an
// asynchronous Clear forces every output low in the same cycle.
//
// Ports:
//   Clock      in   system clock, rising edge
//   Clear      in   asynchronous active-low reset
//   Run_In     in   start request, sampled only in IDLE
//   IR         in   instruction register contents
//   Mem_Ready  in   memory read-complete handshake, sampled only in T1
//   PC_Out, ZLO_Out, MDR_Out                 out  bus drive enables
//   MAR_In, PC_In, MDR_In, IR_In, Y_In, Z_In out  register load enables
//   IncPC, Read                              out  PC increment / mem read
//   CONTROL    out  ALU operation select
//   R_In       out  one-hot general-register load
//   R_Out      out  one-hot general-register bus drive
//   Running    out  high from start until halt
//   Illegal    out  one-cycle pulse on an undefined opcode
// ---------------------------------------------------------------------------
module control_sequencer #(
    parameter int NUM_REGS = 16,
    parameter int OPW      = 5,
    parameter int CTLW     = 5
) (
    input  logic                Clock,
    input  logic                Clear,
    input  logic                Run_In,
    input  logic [31:0]         IR,
    input  logic                Mem_Ready,
    output logic                PC_Out,
    output logic                ZLO_Out,
    output logic                MDR_Out,
    output logic                MAR_In,
    output logic                PC_In,
    output logic                MDR_In,
    output logic                IR_In,
    output logic                Y_In,
    output logic                Z_In,
    output logic                IncPC,
    output logic                Read,
    output logic [CTLW-1:0]     CONTROL,
    output logic [NUM_REGS-1:0] R_In,
    output logic [NUM_REGS-1:0] R_Out,
    output logic                Running,
    output logic                Illegal
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_HALT
    } state_t;

    localparam logic [OPW-1:0] OP_NEG  = OPW'(5'b01001);
    localparam logic [OPW-1:0] OP_NOT  = OPW'(5'b01010);
    localparam logic [OPW-1:0] OP_NOP  = OPW'(5'b11010);
    localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

    localparam logic [NUM_REGS-1:0] ONE_HOT_0 = NUM_REGS'(1);

    state_t state_q, state_d;

    // ------------------------------------------------------------------
    // IR field decode
    // ------------------------------------------------------------------
    logic [OPW-1:0] opcode;
    logic [3:0]     ra, rb, rc;
    logic           is_alu, is_unary, is_binary, is_nop, is_halt;
    logic [OPW-1:0] alu_sel;

    assign opcode = IR[31:27];
    assign ra     = IR[26:23];
    assign rb     = IR[22:19];
    assign rc     = IR[18:15];

    // Low IR bits carry immediates for instruction classes not handled here.
    logic unused_ir_bits;
    assign unused_ir_bits = ^IR[14:0];

    assign is_alu    = (opcode <= OP_NOT);
    assign is_unary  = (opcode == OP_NEG) || (opcode == OP_NOT);
    assign is_binary = is_alu && !is_unary;
    assign is_nop    = (opcode == OP_NOP);
    assign is_halt   = (opcode == OP_HALT);
    assign alu_sel   = opcode + OPW'(1);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: async active-low clear on the sensitivity list, so IDLE (and
    // therefore all-zero outputs) takes effect the instant Clear falls.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every variable assigned here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (Run_In) state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   if (Mem_Ready) state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_T3: begin
                if (is_alu)       state_d = S_T4;
                else if (is_halt) state_d = S_HALT;
                else              state_d = S_T0;   // nop and illegal
            end
            S_T4:   state_d = is_binary ? S_T5 : S_T0;
            S_T5:   state_d = S_T0;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        PC_Out  = 1'b0;
        ZLO_Out = 1'b0;
        MDR_Out = 1'b0;
        MAR_In  = 1'b0;
        PC_In   = 1'b0;
        MDR_In  = 1'b0;
        IR_In   = 1'b0;
        Y_In    = 1'b0;
        Z_In    = 1'b0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        CONTROL = '0;
        R_In    = '0;
        R_Out   = '0;
        Illegal = 1'b0;
        Running = (state_q != S_IDLE) && (state_q != S_HALT);

        unique case (state_q)
            S_T0: begin
                PC_Out = 1'b1;
                MAR_In = 1'b1;
                IncPC  = 1'b1;
                Z_In   = 1'b1;     // Z latches PC+1; CONTROL stays 0
            end
            S_T1: begin
                Read    = 1'b1;
                MDR_In  = 1'b1;
                // Write the incremented PC back only on the completing
                // cycle, so a long wait still advances PC exactly once.
                PC_In   = Mem_Ready;
                ZLO_Out = Mem_Ready;
            end
            S_T2: begin
                MDR_Out = 1'b1;
                IR_In   = 1'b1;
            end
            S_T3: begin
                if (is_binary) begin
                    R_Out = ONE_HOT_0 << rb;
                    Y_In  = 1'b1;
                end else if (is_unary) begin
                    R_Out   = ONE_HOT_0 << rb;
                    Z_In    = 1'b1;
                    CONTROL = CTLW'(alu_sel);
                end else if (!is_nop && !is_halt) begin
                    Illegal = 1'b1;
                end
            end
            S_T4: begin
                if (is_binary) begin
                    R_Out   = ONE_HOT_0 << rc;
                    Z_In    = 1'b1;
                    CONTROL = CTLW'(alu_sel);
                end else if (is_unary) begin
                    ZLO_Out = 1'b1;
                    R_In    = ONE_HOT_0 << ra;
                end
            end
            S_T5: begin
                if (is_binary) begin
                    ZLO_Out = 1'b1;
                    R_In    = ONE_HOT_0 << ra;
                end
            end
            default: ;              // IDLE, HALT: everything stays low
        endcase
    end

endmodule
